// File: rtl/adder_pkg.sv
// Shared definitions for the chunked pipelined adder: op encodings and pipeline sizing.
package adder_pkg;

  localparam logic ADD_OP = 1'b0;
  localparam logic SUB_OP = 1'b1;

  // Returns 1 for a zero chunk so array sizes stay legal long enough for split_ok to report.
  function automatic int unsigned stages_of(input int unsigned width, input int unsigned chunk);
    return (chunk == 0) ? 1 : width / chunk;
  endfunction

  function automatic bit split_ok(input int unsigned width, input int unsigned chunk);
    return (chunk >= 1) && (width >= chunk) && ((width % chunk) == 0);
  endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit ripple adder built from full-adder cells; also exposes the
// carry into its MSB so the final stage can derive signed overflow.
module chunk_adder #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [CHUNK:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign sum[i]  = a[i] ^ b[i] ^ c[i];
    assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout  = c[CHUNK];
  assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/pipelined_chunk_adder.sv
// Pipelined WIDTH-bit add/subtract: one CHUNK-bit ripple segment per register stage,
// with the carry and the not-yet-added operand bits travelling alongside each operation.
module pipelined_chunk_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int unsigned STAGES = stages_of(WIDTH, CHUNK);

  if (!split_ok(WIDTH, CHUNK)) begin : g_split_check
    $error("pipelined_chunk_adder: WIDTH must be a non-zero multiple of CHUNK");
  end

  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] carry_q;
  logic [WIDTH-1:0]  acc_q [STAGES];
  logic [WIDTH-1:0]  opb_q [STAGES];
  logic              ovf_q;

  logic [STAGES-1:0] ld;
  logic [STAGES-1:0] src_v;
  logic [STAGES-1:0] src_c;
  logic [WIDTH-1:0]  src_a [STAGES];
  logic [WIDTH-1:0]  src_b [STAGES];
  logic [CHUNK-1:0]  sum_c [STAGES];
  logic [STAGES-1:0] cout_c;
  logic              cmsb_c [STAGES];
  logic [WIDTH-1:0]  acc_d [STAGES];
  logic [WIDTH-1:0]  opb_d [STAGES];

  // A stage loads when its occupant moves on or it holds a bubble, so bubbles collapse.
  always_comb begin
    logic go;
    ld = '0;
    go = out_ready;
    for (int unsigned k = STAGES; k > 0; k--) begin
      go        = go | ~valid_q[k-1];
      ld[k-1]   = go;
    end
  end

  assign in_ready = ld[0];

  assign src_v[0] = in_valid;
  assign src_a[0] = in_a;
  assign src_b[0] = (in_sub == ADD_OP) ? in_b : ~in_b;
  assign src_c[0] = (in_sub == SUB_OP) ? 1'b1 : in_cin;

  for (genvar k = 1; k < STAGES; k++) begin : g_link
    assign src_v[k] = valid_q[k-1];
    assign src_a[k] = acc_q[k-1];
    assign src_b[k] = opb_q[k-1];
    assign src_c[k] = carry_q[k-1];
  end

  // acc shifts right by one chunk per stage; resolved chunks enter at the top, so after
  // the last stage the word holds the sum in natural order with no reassembly.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    chunk_adder #(.CHUNK(CHUNK)) u_chunk (
      .a     (src_a[k][CHUNK-1:0]),
      .b     (src_b[k][CHUNK-1:0]),
      .cin   (src_c[k]),
      .sum   (sum_c[k]),
      .cout  (cout_c[k]),
      .c_msb (cmsb_c[k])
    );
    assign acc_d[k] = (src_a[k] >> CHUNK) | (WIDTH'(sum_c[k]) << (WIDTH - CHUNK));
    assign opb_d[k] = src_b[k] >> CHUNK;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      carry_q <= '0;
      ovf_q   <= 1'b0;
      for (int unsigned k = 0; k < STAGES; k++) begin
        acc_q[k] <= '0;
        opb_q[k] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        if (ld[k]) begin
          valid_q[k] <= src_v[k];
          if (src_v[k]) begin
            acc_q[k]   <= acc_d[k];
            opb_q[k]   <= opb_d[k];
            carry_q[k] <= cout_c[k];
          end
        end
      end
      if (ld[STAGES-1] && src_v[STAGES-1]) begin
        ovf_q <= cmsb_c[STAGES-1] ^ cout_c[STAGES-1];
      end
    end
  end

  assign out_valid = valid_q[STAGES-1];
  assign out_sum   = acc_q[STAGES-1];
  assign out_cout  = carry_q[STAGES-1];
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_pipelined_chunk_adder.sv
// Directed bench for pipelined_chunk_adder (WIDTH=16, CHUNK=4) with an in-order scoreboard.
module tb_pipelined_chunk_adder;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned CHUNK = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;

  always #5 clk = ~clk;

  pipelined_chunk_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf)
  );

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } res_t;

  res_t        exp_q [$];
  int unsigned acc_cyc_q [$];
  int unsigned out_cyc_q [$];
  res_t        mon_e;
  int unsigned mon_ac;

  int unsigned cyc     = 0;
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned n_out   = 0;
  int unsigned n_base;
  logic [15:0] exp_sum;
  logic        exp_cout;
  logic        exp_ovf;
  bit          lat_on;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: operands are paired with hand-computed results when accepted.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      acc_cyc_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_out++;
        out_cyc_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          check("unexpected_out", 32'(out_valid), 32'h0);
        end else begin
          mon_e  = exp_q.pop_front();
          mon_ac = acc_cyc_q.pop_front();
          check("sum",  32'(out_sum),  32'(mon_e.sum));
          check("cout", 32'(out_cout), 32'(mon_e.cout));
          check("ovf",  32'(out_ovf),  32'(mon_e.ovf));
          if (lat_on) check("latency", cyc - mon_ac, 32'd4);
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back('{sum: exp_sum, cout: exp_cout, ovf: exp_ovf});
        acc_cyc_q.push_back(cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves in_valid high so consecutive calls stream back to back.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub,
                      input logic [15:0] es, input logic ec, input logic eo);
    in_a = a; in_b = b; in_cin = cin; in_sub = sub;
    exp_sum = es; exp_cout = ec; exp_ovf = eo;
    in_valid = 1'b1;
    for (int unsigned n = 0; n < 32; n++) begin
      @(negedge clk);
      if (in_ready) begin
        tick();
        return;
      end
    end
    check("send_timeout", 32'(in_ready), 32'h1);
    tick();
  endtask

  task automatic drain();
    for (int unsigned n = 0; n < 40; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) break;
    end
    check("drain_empty", 32'(exp_q.size()), 32'h0);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;
    out_ready = 1'b1; lat_on = 1'b0; exp_sum = '0; exp_cout = 1'b0; exp_ovf = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_sum",   32'(out_sum),   32'h0);
    check("rst_out_cout",  32'(out_cout),  32'h0);
    check("rst_out_ovf",   32'(out_ovf),   32'h0);
    check("rst_in_ready",  32'(in_ready),  32'h1);
    tick();

    // Single ops, unstalled: latency checked in the scoreboard.
    lat_on = 1'b1;
    send(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0); in_valid = 1'b0; drain();
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0); in_valid = 1'b0; drain();
    send(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0); in_valid = 1'b0; drain();
    send(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1); in_valid = 1'b0; drain();
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1); in_valid = 1'b0; drain();
    send(16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0); in_valid = 1'b0; drain();
    send(16'h0010, 16'h0010, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0); in_valid = 1'b0; drain();

    // Eight back-to-back ops with out_ready=1.
    out_cyc_q.delete();
    send(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);
    send(16'h00F0, 16'h0010, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
    send(16'h0F00, 16'h0100, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);
    send(16'hF000, 16'h1000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    send(16'h1111, 16'h0111, 1'b0, 1'b1, 16'h1000, 1'b1, 1'b0);
    send(16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0);
    send(16'h4000, 16'h4000, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    send(16'hABCD, 16'h1234, 1'b0, 1'b0, 16'hBE01, 1'b0, 1'b0);
    in_valid = 1'b0;
    drain();
    check("stream_count", 32'(out_cyc_q.size()), 32'd8);
    if (out_cyc_q.size() >= 8) check("stream_span", out_cyc_q[7] - out_cyc_q[0], 32'd7);

    // Backpressure: four accepts fill the pipe, then in_ready drops and outputs hold.
    lat_on = 1'b0;
    n_base = n_out;
    out_ready = 1'b0;
    send(16'h0100, 16'h0200, 1'b0, 1'b0, 16'h0300, 1'b0, 1'b0);
    send(16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0);
    send(16'h1000, 16'h0001, 1'b0, 1'b1, 16'h0FFF, 1'b1, 1'b0);
    send(16'h2222, 16'h1111, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0);
    in_a = 16'hFFFF; in_b = 16'hFFFF; in_cin = 1'b0; in_sub = 1'b0;
    exp_sum = 16'hFFFE; exp_cout = 1'b1; exp_ovf = 1'b0;
    for (int unsigned n = 0; n < 6; n++) begin
      @(negedge clk);
      check("stall_in_ready",  32'(in_ready),  32'h0);
      check("stall_out_valid", 32'(out_valid), 32'h1);
      check("stall_out_sum",   32'(out_sum),   32'h0300);
      check("stall_out_cout",  32'(out_cout),  32'h0);
    end
    tick();
    out_ready = 1'b1;
    @(negedge clk);
    check("release_in_ready", 32'(in_ready), 32'h1);
    tick();
    in_valid = 1'b0;
    drain();
    check("stall_result_count", n_out - n_base, 32'd5);

    // Bubble collapse under a stalled output.
    n_base = n_out;
    out_ready = 1'b0;
    send(16'h0010, 16'h0020, 1'b0, 1'b0, 16'h0030, 1'b0, 1'b0);
    in_valid = 1'b0;
    tick();
    tick();
    send(16'h0100, 16'h0100, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
    send(16'h7000, 16'h7000, 1'b0, 1'b0, 16'hE000, 1'b0, 1'b1);
    send(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    in_valid = 1'b0;
    @(negedge clk);
    check("bubble_full_in_ready", 32'(in_ready),  32'h0);
    check("bubble_out_valid",     32'(out_valid), 32'h1);
    check("bubble_head_sum",      32'(out_sum),   32'h0030);
    tick();
    out_cyc_q.delete();
    out_ready = 1'b1;
    drain();
    check("bubble_count", n_out - n_base, 32'd4);
    if (out_cyc_q.size() >= 4) check("bubble_span", out_cyc_q[3] - out_cyc_q[0], 32'd3);

    // Reset with three ops in flight: nothing may emerge afterwards.
    lat_on = 1'b1;
    n_base = n_out;
    send(16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0);
    send(16'h0004, 16'h0005, 1'b0, 1'b0, 16'h0009, 1'b0, 1'b0);
    send(16'h0006, 16'h0007, 1'b0, 1'b0, 16'h000D, 1'b0, 1'b0);
    in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'h1);
    check("post_rst_out_sum",  32'(out_sum),  32'h0);
    for (int unsigned n = 0; n < 6; n++) begin
      check("post_rst_out_valid", 32'(out_valid), 32'h0);
      @(negedge clk);
    end
    tick();
    check("post_rst_no_output", n_out - n_base, 32'd0);
    send(16'h1234, 16'h0234, 1'b0, 1'b1, 16'h1000, 1'b1, 1'b0);
    in_valid = 1'b0;
    drain();
    check("post_rst_result_count", n_out - n_base, 32'd1);

    check("leftover_expected", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
